// File: rtl/alu_cu_sequencer_if.sv
// Instruction handshake between an instruction source and the ALU control sequencer.
interface alu_cu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    // Source side: offers instructions and holds them until accepted.
    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    // Sequencer side: accepts one instruction at a time while idle.
    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/alu_cu_sequencer.sv
// Multi-cycle control unit for an external combinational ALU: fetches operands
// from a small register file, drives registered A/B/opcode, then writes the
// result back and updates the sticky Z/N/C flags. One instruction per 3 cycles.
module alu_cu_sequencer #(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned DW     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_cu_sequencer_if.slave     bus,
    input  logic                  i_pl_en,
    input  logic [REG_AW-1:0]     i_pl_addr,
    input  logic [DW-1:0]         i_pl_data,
    input  logic [REG_AW-1:0]     i_dbg_addr,
    output logic [DW-1:0]         o_dbg_data_c,
    output logic [DW-1:0]         o_alu_a,
    output logic [DW-1:0]         o_alu_b,
    output logic [5:0]            o_alu_op,
    input  logic [DW-1:0]         i_alu_ans1,
    input  logic                  i_alu_ans2,
    input  logic                  i_alu_z,
    input  logic                  i_alu_n,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_flag_z,
    output logic                  o_flag_n,
    output logic                  o_flag_c
);

    localparam int unsigned DEPTH = 2 ** REG_AW;
    localparam int unsigned OPW   = 6;

    localparam logic [OPW-1:0] OP_ADD = 6'b010000;
    localparam logic [OPW-1:0] OP_SUB = 6'b010001;
    localparam logic [OPW-1:0] OP_EQ  = 6'b100000;
    localparam logic [OPW-1:0] OP_NE  = 6'b100001;
    localparam logic [OPW-1:0] OP_LE  = 6'b100010;
    localparam logic [OPW-1:0] OP_GT  = 6'b100011;
    localparam logic [OPW-1:0] OP_SLL = 6'b110000;
    localparam logic [OPW-1:0] OP_SRL = 6'b110001;
    localparam logic [OPW-1:0] OP_SRA = 6'b110010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_ready;
    logic               r_done;
    logic               r_err;
    logic [DW-1:0]      r_alu_a;
    logic [DW-1:0]      r_alu_b;
    logic [OPW-1:0]     r_alu_op;
    logic [REG_AW-1:0]  r_rd;
    logic               r_flag_z;
    logic               r_flag_n;
    logic               r_flag_c;
    logic [DW-1:0]      r_regs [DEPTH];

    logic               w_accept;
    logic               w_retire;
    logic               w_legal;
    logic               w_is_cmp;
    logic               w_pl_we;
    logic [REG_AW-1:0]  w_rd;
    logic [REG_AW-1:0]  w_rs1;
    logic [REG_AW-1:0]  w_rs2;
    logic [OPW-1:0]     w_opcode;
    logic [DW-1:0]      w_wb_data;
    logic               w_unused_instr;

    // Instruction field extraction; only the low REG_AW bits of each address count.
    assign w_opcode       = bus.instr[31:26];
    assign w_rd           = bus.instr[21 +: REG_AW];
    assign w_rs1          = bus.instr[16 +: REG_AW];
    assign w_rs2          = bus.instr[11 +: REG_AW];
    assign w_unused_instr = ^bus.instr;

    // Next-state and per-cycle strobes for the IDLE -> EXEC -> WB sequence.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_retire     = 1'b1;
                w_next_state = S_WB;
            end
            S_WB: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Opcode classification of the instruction currently held in the ALU registers.
    always_comb begin
        w_legal  = 1'b0;
        w_is_cmp = 1'b0;
        case (r_alu_op)
            OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA: begin
                w_legal = 1'b1;
            end
            OP_EQ, OP_NE, OP_LE, OP_GT: begin
                w_legal  = 1'b1;
                w_is_cmp = 1'b1;
            end
            default: begin
                w_legal  = 1'b0;
                w_is_cmp = 1'b0;
            end
        endcase
    end

    // Compare ops retire the single compare bit, everything else the full result.
    assign w_wb_data = w_is_cmp ? DW'(i_alu_ans2) : i_alu_ans1;

    // Preload only while idle, and an accepted instruction takes priority over it.
    assign w_pl_we = (r_state == S_IDLE) && i_pl_en && !w_accept;

    // State register plus the registered handshake and retire indications.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == S_IDLE);
            r_done  <= w_retire;
            r_err   <= w_retire && !w_legal;
        end
    end

    // Operand fetch on accept, register-file writes and sticky flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_rd     <= '0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_c <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_alu_a  <= r_regs[w_rs1];
                r_alu_b  <= r_regs[w_rs2];
                r_alu_op <= w_opcode;
                r_rd     <= w_rd;
            end
            if (w_pl_we) begin
                r_regs[i_pl_addr] <= i_pl_data;
            end
            if (w_retire && w_legal) begin
                r_regs[r_rd] <= w_wb_data;
                r_flag_z     <= i_alu_z;
                r_flag_n     <= i_alu_n;
                r_flag_c     <= i_alu_ans2;
            end
        end
    end

    assign bus.instr_ready = r_ready;
    assign o_dbg_data_c    = r_regs[i_dbg_addr];
    assign o_alu_a         = r_alu_a;
    assign o_alu_b         = r_alu_b;
    assign o_alu_op        = r_alu_op;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_flag_z        = r_flag_z;
    assign o_flag_n        = r_flag_n;
    assign o_flag_c        = r_flag_c;

endmodule

// File: tb/tb_alu_cu_sequencer.sv
// Directed bench for alu_cu_sequencer with a behavioural 32-bit ALU attached.
module tb_alu_cu_sequencer;

    logic        clk;
    logic        rst;
    logic        pl_en;
    logic [2:0]  pl_addr;
    logic [31:0] pl_data;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_op;
    logic [31:0] alu_ans1;
    logic        alu_ans2;
    logic        alu_z;
    logic        alu_n;
    logic        done;
    logic        err;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;

    int n_pass;
    int n_total;

    alu_cu_sequencer_if u_if ();

    alu_cu_sequencer #(.REG_AW(3), .DW(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (u_if),
        .i_pl_en      (pl_en),
        .i_pl_addr    (pl_addr),
        .i_pl_data    (pl_data),
        .i_dbg_addr   (dbg_addr),
        .o_dbg_data_c (dbg_data),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_ans1   (alu_ans1),
        .i_alu_ans2   (alu_ans2),
        .i_alu_z      (alu_z),
        .i_alu_n      (alu_n),
        .o_done       (done),
        .o_err        (err),
        .o_flag_z     (flag_z),
        .o_flag_n     (flag_n),
        .o_flag_c     (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: carry/borrow on add/sub, compare bit on compares.
    always_comb begin
        logic [32:0] sum;
        sum      = 33'd0;
        alu_ans1 = 32'd0;
        alu_ans2 = 1'b0;
        case (alu_op)
            6'b010000: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_ans1 = sum[31:0]; alu_ans2 = sum[32]; end
            6'b010001: begin sum = {1'b0, alu_a} - {1'b0, alu_b}; alu_ans1 = sum[31:0]; alu_ans2 = sum[32]; end
            6'b100000: alu_ans2 = (alu_a == alu_b);
            6'b100001: alu_ans2 = (alu_a != alu_b);
            6'b100010: alu_ans2 = ($signed(alu_a) <= $signed(alu_b));
            6'b100011: alu_ans2 = ($signed(alu_a) > $signed(alu_b));
            6'b110000: alu_ans1 = alu_a << alu_b[4:0];
            6'b110001: alu_ans1 = alu_a >> alu_b[4:0];
            6'b110010: alu_ans1 = $signed(alu_a) >>> alu_b[4:0];
            default:   alu_ans1 = 32'd0;
        endcase
        if (alu_op[5:4] == 2'b10) alu_ans1 = {31'd0, alu_ans2};
        alu_z = (alu_ans1 == 32'd0);
        alu_n = alu_ans1[31];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int addr, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_addr = 3'(addr);
        pl_data = data;
        tick();
        pl_en   = 1'b0;
    endtask

    // Issue one instruction from IDLE and check the full accept/exec/retire timing.
    task automatic run_instr(input string name, input logic [5:0] op, input int rd, input int rs1,
                             input int rs2, input logic [31:0] exp_a, input logic [31:0] exp_b,
                             input logic exp_err);
        n_total++;
        if (u_if.instr_ready !== 1'b1) $display("FAIL %s ready_idle got %b exp 1", name, u_if.instr_ready);
        else n_pass++;
        u_if.instr       = {op, 5'(rd), 5'(rs1), 5'(rs2), 11'd0};
        u_if.instr_valid = 1'b1;
        tick();
        u_if.instr_valid = 1'b0;
        n_total++;
        if (u_if.instr_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL %s exec_ctl got ready=%b done=%b exp 0/0", name, u_if.instr_ready, done);
        else n_pass++;
        n_total++;
        if (alu_a !== exp_a || alu_b !== exp_b || alu_op !== op)
            $display("FAIL %s operands got %h %h %b exp %h %h %b", name, alu_a, alu_b, alu_op, exp_a, exp_b, op);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b1 || err !== exp_err || u_if.instr_ready !== 1'b0)
            $display("FAIL %s retire got done=%b err=%b ready=%b exp 1/%b/0", name, done, err, u_if.instr_ready, exp_err);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0 || u_if.instr_ready !== 1'b1)
            $display("FAIL %s back_idle got done=%b ready=%b exp 0/1", name, done, u_if.instr_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_total++;
        if (u_if.instr_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_ctl got ready=%b done=%b err=%b exp 1/0/0", u_if.instr_ready, done, err);
        else n_pass++;
        n_total++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 6'd0 || {flag_z, flag_n, flag_c} !== 3'b000)
            $display("FAIL reset_regs got a=%h b=%h op=%b flags=%b exp zeros", alu_a, alu_b, alu_op, {flag_z, flag_n, flag_c});
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            n_total++;
            if (dbg_data !== 32'd0) $display("FAIL reset_rf[%0d] got %h exp 0", i, dbg_data);
            else n_pass++;
        end
    endtask

    task automatic test_add();
        preload(1, 32'h0000_0001);
        preload(2, 32'h0000_0001);
        run_instr("add", 6'b010000, 3, 1, 2, 32'h1, 32'h1, 1'b0);
        dbg_addr = 3'd3;
        #1;
        n_total++;
        if (dbg_data !== 32'h0000_0002) $display("FAIL add_r3 got %h exp 00000002", dbg_data);
        else n_pass++;
        n_total++;
        if ({flag_z, flag_n, flag_c} !== 3'b000) $display("FAIL add_flags got znc=%b exp 000", {flag_z, flag_n, flag_c});
        else n_pass++;
    endtask

    task automatic test_add_carry();
        preload(4, 32'hffff_ffff);
        preload(5, 32'hffff_fffe);
        run_instr("add_carry", 6'b010000, 6, 4, 5, 32'hffff_ffff, 32'hffff_fffe, 1'b0);
        dbg_addr = 3'd6;
        #1;
        n_total++;
        if (dbg_data !== 32'hffff_fffd) $display("FAIL add_carry_r6 got %h exp fffffffd", dbg_data);
        else n_pass++;
        n_total++;
        if ({flag_z, flag_n, flag_c} !== 3'b011) $display("FAIL add_carry_flags got znc=%b exp 011", {flag_z, flag_n, flag_c});
        else n_pass++;
    endtask

    task automatic test_sub_cmp();
        run_instr("sub", 6'b010001, 7, 1, 1, 32'h1, 32'h1, 1'b0);
        dbg_addr = 3'd7;
        #1;
        n_total++;
        if (dbg_data !== 32'd0 || {flag_z, flag_n, flag_c} !== 3'b100)
            $display("FAIL sub_r7 got %h znc=%b exp 00000000 100", dbg_data, {flag_z, flag_n, flag_c});
        else n_pass++;
        run_instr("gt", 6'b100011, 2, 4, 1, 32'hffff_ffff, 32'h1, 1'b0);
        dbg_addr = 3'd2;
        #1;
        n_total++;
        if (dbg_data !== 32'd0 || flag_c !== 1'b0) $display("FAIL gt_r2 got %h c=%b exp 00000000 0", dbg_data, flag_c);
        else n_pass++;
        run_instr("eq", 6'b100000, 7, 1, 3, 32'h1, 32'h2, 1'b0);
        run_instr("le", 6'b100010, 7, 4, 1, 32'hffff_ffff, 32'h1, 1'b0);
        dbg_addr = 3'd7;
        #1;
        n_total++;
        if (dbg_data !== 32'h1 || {flag_z, flag_n, flag_c} !== 3'b001)
            $display("FAIL le_r7 got %h znc=%b exp 00000001 001", dbg_data, {flag_z, flag_n, flag_c});
        else n_pass++;
    endtask

    task automatic test_shift();
        run_instr("sll", 6'b110000, 0, 5, 1, 32'hffff_fffe, 32'h1, 1'b0);
        run_instr("sra", 6'b110010, 7, 0, 1, 32'hffff_fffc, 32'h1, 1'b0);
        run_instr("srl", 6'b110001, 2, 0, 1, 32'hffff_fffc, 32'h1, 1'b0);
        dbg_addr = 3'd0;
        #1;
        n_total++;
        if (dbg_data !== 32'hffff_fffc) $display("FAIL sll_r0 got %h exp fffffffc", dbg_data);
        else n_pass++;
        dbg_addr = 3'd7;
        #1;
        n_total++;
        if (dbg_data !== 32'hffff_fffe) $display("FAIL sra_r7 got %h exp fffffffe", dbg_data);
        else n_pass++;
        dbg_addr = 3'd2;
        #1;
        n_total++;
        if (dbg_data !== 32'h7fff_fffe || {flag_z, flag_n, flag_c} !== 3'b000)
            $display("FAIL srl_r2 got %h znc=%b exp 7ffffffe 000", dbg_data, {flag_z, flag_n, flag_c});
        else n_pass++;
        // NE of equal operands leaves flags z=1 n=0 c=0 as a known baseline
        run_instr("ne", 6'b100001, 3, 1, 1, 32'h1, 32'h1, 1'b0);
        n_total++;
        if ({flag_z, flag_n, flag_c} !== 3'b100) $display("FAIL ne_flags got znc=%b exp 100", {flag_z, flag_n, flag_c});
        else n_pass++;
        run_instr("add_r3", 6'b010000, 3, 1, 1, 32'h1, 32'h1, 1'b0);
        run_instr("eq_r7", 6'b100000, 7, 1, 1, 32'h1, 32'h1, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr("ill_3f", 6'b111111, 6, 1, 2, 32'h1, 32'h7fff_fffe, 1'b1);
        run_instr("ill_00", 6'b000000, 1, 3, 4, 32'h2, 32'hffff_ffff, 1'b1);
        dbg_addr = 3'd6;
        #1;
        n_total++;
        if (dbg_data !== 32'hffff_fffd) $display("FAIL ill_r6 got %h exp fffffffd", dbg_data);
        else n_pass++;
        dbg_addr = 3'd1;
        #1;
        n_total++;
        if (dbg_data !== 32'h1) $display("FAIL ill_r1 got %h exp 00000001", dbg_data);
        else n_pass++;
        n_total++;
        if ({flag_z, flag_n, flag_c} !== 3'b001) $display("FAIL ill_flags got znc=%b exp 001", {flag_z, flag_n, flag_c});
        else n_pass++;
    endtask

    task automatic test_preload_rules();
        pl_en            = 1'b1;
        pl_addr          = 3'd5;
        pl_data          = 32'h1234_5678;
        u_if.instr       = {6'b010000, 5'd0, 5'd1, 5'd1, 11'd0};
        u_if.instr_valid = 1'b1;
        tick();
        u_if.instr_valid = 1'b0;
        tick();
        n_total++;
        if (done !== 1'b1 || err !== 1'b0) $display("FAIL pl_done got done=%b err=%b exp 1/0", done, err);
        else n_pass++;
        tick();
        pl_en    = 1'b0;
        dbg_addr = 3'd5;
        #1;
        n_total++;
        if (dbg_data !== 32'hffff_fffe) $display("FAIL pl_dropped_r5 got %h exp fffffffe", dbg_data);
        else n_pass++;
        dbg_addr = 3'd0;
        #1;
        n_total++;
        if (dbg_data !== 32'h2) $display("FAIL pl_add_r0 got %h exp 00000002", dbg_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        u_if.instr       = {6'b010000, 5'd3, 5'd3, 5'd1, 11'd0};
        u_if.instr_valid = 1'b1;
        tick();
        u_if.instr = {6'b010001, 5'd4, 5'd3, 5'd1, 11'd0};
        n_total++;
        if (u_if.instr_ready !== 1'b0 || alu_op !== 6'b010000 || alu_a !== 32'h2)
            $display("FAIL b2b_first got ready=%b op=%b a=%h exp 0/010000/00000002", u_if.instr_ready, alu_op, alu_a);
        else n_pass++;
        tick();
        n_total++;
        if (u_if.instr_ready !== 1'b0 || done !== 1'b1)
            $display("FAIL b2b_wb1 got ready=%b done=%b exp 0/1", u_if.instr_ready, done);
        else n_pass++;
        tick();
        n_total++;
        if (u_if.instr_ready !== 1'b1 || done !== 1'b0 || alu_op !== 6'b010000)
            $display("FAIL b2b_idle got ready=%b done=%b op=%b exp 1/0/010000", u_if.instr_ready, done, alu_op);
        else n_pass++;
        tick();
        u_if.instr_valid = 1'b0;
        n_total++;
        if (u_if.instr_ready !== 1'b0 || alu_op !== 6'b010001 || alu_a !== 32'h3 || alu_b !== 32'h1)
            $display("FAIL b2b_second got ready=%b op=%b a=%h b=%h exp 0/010001/00000003/00000001",
                     u_if.instr_ready, alu_op, alu_a, alu_b);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b1) $display("FAIL b2b_wb2 got done=%b exp 1", done);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (done !== 1'b0 || u_if.instr_ready !== 1'b1)
                $display("FAIL b2b_quiet[%0d] got done=%b ready=%b exp 0/1", i, done, u_if.instr_ready);
            else n_pass++;
        end
        dbg_addr = 3'd4;
        #1;
        n_total++;
        if (dbg_data !== 32'h2) $display("FAIL b2b_r4 got %h exp 00000002", dbg_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid_exec();
        u_if.instr       = {6'b010000, 5'd3, 5'd1, 5'd1, 11'd0};
        u_if.instr_valid = 1'b1;
        tick();
        u_if.instr_valid = 1'b0;
        rst              = 1'b1;
        tick();
        n_total++;
        if (done !== 1'b0 || u_if.instr_ready !== 1'b1)
            $display("FAIL rst_exec got done=%b ready=%b exp 0/1", done, u_if.instr_ready);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_total++;
        if (done !== 1'b0 || u_if.instr_ready !== 1'b1 || alu_op !== 6'd0 || {flag_z, flag_n, flag_c} !== 3'b000)
            $display("FAIL rst_after got done=%b ready=%b op=%b znc=%b exp 0/1/000000/000",
                     done, u_if.instr_ready, alu_op, {flag_z, flag_n, flag_c});
        else n_pass++;
        dbg_addr = 3'd3;
        #1;
        n_total++;
        if (dbg_data !== 32'd0) $display("FAIL rst_r3 got %h exp 00000000", dbg_data);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0) $display("FAIL rst_no_done got done=%b exp 0", done);
        else n_pass++;
    endtask

    initial begin
        n_pass           = 0;
        n_total          = 0;
        rst              = 1'b1;
        pl_en            = 1'b0;
        pl_addr          = 3'd0;
        pl_data          = 32'd0;
        dbg_addr         = 3'd0;
        u_if.instr_valid = 1'b0;
        u_if.instr       = 32'd0;
        test_reset();
        test_add();
        test_add_carry();
        test_sub_cmp();
        test_shift();
        test_illegal();
        test_preload_rules();
        test_back_to_back();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_cu_sequencer.md
Name: alu_cu_sequencer

Overview:
Multi-cycle control unit that drives the team's combinational 32-bit ALU. It accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal register file. It presents registered A/B/opCode to the ALU, then writes the ALU result back and updates the Z/N/C flags. The ALU sits outside this block and connects through the alu_* ports.

Parameters:
REG_AW, 3, register-file address width; depth = 2**REG_AW words of 32 bits.
DW, 32, datapath width; must match the ALU.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  block can accept an instruction (high only in IDLE)
instr  in  32  [31:26] opcode, [25:21] rd, [20:16] rs1, [15:11] rs2; only the low REG_AW bits of each address are used
pl_en  in  1  register preload strobe, honoured only in IDLE
pl_addr  in  REG_AW  preload address
pl_data  in  DW  preload data
dbg_addr  in  REG_AW  debug read address
dbg_data  out  DW  combinational register-file read at dbg_addr
alu_a  out  DW  ALU operand A (registered)
alu_b  out  DW  ALU operand B (registered)
alu_op  out  6  ALU opCode (registered)
alu_ans1  in  DW  ALU result
alu_ans2  in  1  ALU carry/borrow out for add/sub; compare result for compare ops
alu_z  in  1  ALU zero flag
alu_n  in  1  ALU negative flag
done  out  1  one-cycle pulse: instruction retired
err  out  1  valid only with done; high when the opcode is illegal
flag_z  out  1  sticky zero flag
flag_n  out  1  sticky negative flag
flag_c  out  1  sticky carry/compare flag

Behaviour:
- Legal opcodes:
  - 010000 ADD, 010001 SUB
  - 100000 EQ, 100001 NE, 100010 LE, 100011 GT
  - 110000 SLL, 110001 SRL, 110010 SRA
  - All other opcodes are illegal.
- Reset: state=IDLE; alu_a, alu_b, alu_op=0; done, err=0; flags=0; all registers cleared to 0.
- Reset overrides everything, including mid-EXEC or WB: no writeback occurs and done stays low.
- FSM states: IDLE, EXEC, WB.
  - IDLE: instr_ready=1. On instr_valid at the edge, latch the instruction and load alu_a=R[rs1], alu_b=R[rs2], alu_op=opcode, then go to EXEC.
  - IDLE preload: if pl_en=1 and no instruction is accepted in that cycle, R[pl_addr] is written with pl_data. If instr_valid and pl_en are both high, the instruction wins and the preload is dropped.
  - EXEC: instr_ready=0; alu_* outputs are held stable.
    - At the edge ending EXEC, for a legal opcode: write back and capture flags (below).
    - For an illegal opcode: no register write, flags unchanged, err is set.
    - Then go to WB.
  - WB: done=1 for exactly this cycle, err valid alongside it; go to IDLE.
- Writeback rules:
  - Arithmetic and shift ops: R[rd]=alu_ans1.
  - Compare ops: R[rd]={31'b0, alu_ans2}.
  - Flags: flag_z=alu_z, flag_n=alu_n, flag_c=alu_ans2.
- Latency: instruction accepted at edge T; retired at the edge ending T+1; done high during cycle T+2. Next accept possible at edge T+3. Throughput is one instruction per 3 cycles.
- Reads see completed writes only. If rd equals rs1 of the next instruction, the next instruction reads the new value; there is no forwarding issue because writeback precedes the next accept.
- instr_valid asserted while instr_ready=0 is ignored. The source must hold it until it is accepted in IDLE.
- All register addresses, including rd=0, are writable; there is no hardwired zero register.
- dbg_data reflects writes on the cycle after the write edge.
- No arithmetic is performed here: results and flags come from the ALU unmodified, truncated to DW.

Test Plan:
- Preload R1=0x00000001, R2=0x00000001; ADD rd=3 -> done at cycle T+2, R3=0x00000002, flag_c=0, flag_z=0, err=0.
- Preload R4=0xffffffff, R5=0xfffffffe; ADD rd=6 -> R6=0xfffffffd, flag_c=1, flag_n=1.
- SUB R1-R1 into rd=7 -> R7=0x00000000, flag_z=1. Then GT R4,R1 with a signed ALU -> R[rd]=0x00000000, flag_c=0.
- Opcode 111111 -> done with err=1, no register change (checked via dbg_addr), flags unchanged from the previous op.
- Hold instr_valid high continuously over two instructions -> instr_ready low in EXEC and WB, second instruction accepted exactly 3 cycles after the first, no duplicate issue.
- Assert rst during EXEC of ADD rd=3 -> no done pulse, R3=0, state IDLE with instr_ready=1 on the cycle after reset deasserts.
